uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter)
// and baud-divider derivation helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam int unsigned DEFAULT_CLK_RATE  = 27_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE = 115_200;
  localparam int unsigned DATA_BITS         = 8;

  // Clock cycles per serial bit (integer divide).
  function automatic int unsigned calc_clk_div(input int unsigned clk_rate,
                                               input int unsigned baud_rate);
    return clk_rate / baud_rate;
  endfunction

  // Cycles from the start-bit edge to its centre.
  function automatic int unsigned calc_half(input int unsigned clk_rate,
                                            input int unsigned baud_rate);
    return calc_clk_div(clk_rate, baud_rate) / 2;
  endfunction

  // Counter width able to hold div-1.
  function automatic int unsigned calc_cnt_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampling FSM, single-entry holding register with
// valid/ready handshake, frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_rate  = DEFAULT_CLK_RATE,
  parameter int unsigned baud_rate = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CLK_DIV = calc_clk_div(clk_rate, baud_rate);
  localparam int unsigned HALF    = calc_half(clk_rate, baud_rate);
  localparam int unsigned CNT_W   = calc_cnt_w(CLK_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  logic             rx_s;
  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A consumer handshake frees the holding register; a completing frame
      // below may refill it in the same cycle.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end

        ST_START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Line held low past the stop bit: wait for idle before hunting again.
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames generated at bit level,
// received bytes and error pulses checked against a queue-based model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_RATE  = 12_800_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned BIT       = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int tests_run    = 0;
  int tests_failed = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int exp_fe  = 0;
  int exp_ov  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(
    .clk_rate  (CLK_RATE),
    .baud_rate (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every accepted byte must be the oldest one the model expects.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  task automatic line_bit(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    line_bit(1'b1, n);
  endtask

  // One 8N1 frame; the model decides delivery vs overrun vs frame error.
  task automatic send_byte(input logic [7:0] b, input int unsigned per, input logic stop_ok);
    line_bit(1'b0, per);
    for (int i = 0; i < 8; i++) line_bit(b[i], per);
    if (stop_ok) begin
      if (exp_q.size() == 0 || rx_ready) exp_q.push_back(b);
      else exp_ov++;
    end else begin
      exp_fe++;
    end
    line_bit(stop_ok, per);
  endtask

  task automatic drain();
    idle(2 * BIT);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("frame_err_cnt", 32'(fe_cnt), 32'(exp_fe));
    check("overrun_cnt", 32'(ov_cnt), 32'(exp_ov));
  endtask

  initial begin
    logic [7:0] b;
    int unsigned per;

    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_state_idle", 32'(dut.state == ST_IDLE), 32'd1);
    rst = 1'b0;
    idle(BIT);

    // Basic frame
    send_byte(8'h41, BIT, 1'b1);
    drain();

    // Start glitch shorter than half a bit
    line_bit(1'b0, 50);
    idle(2 * BIT);
    check("glitch_state_idle", 32'(dut.state == ST_IDLE), 32'd1);
    send_byte(8'h5A, BIT, 1'b1);
    drain();

    // Low stop bit followed by a held-low line
    send_byte(8'h55, BIT, 1'b0);
    line_bit(1'b0, BIT);
    check("break_state", 32'(dut.state == ST_BREAK), 32'd1);
    line_bit(1'b0, BIT);
    idle(BIT);
    check("break_exit_idle", 32'(dut.state == ST_IDLE), 32'd1);
    send_byte(8'h42, BIT, 1'b1);
    drain();

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send_byte(8'h41, BIT, 1'b1);
    send_byte(8'h42, BIT, 1'b1);
    idle(BIT);
    check("hold_valid", 32'(rx_valid), 32'd1);
    check("hold_data", 32'(rx_data), 32'h41);
    check("overrun_once", 32'(ov_cnt), 32'd1);
    rx_ready = 1'b1;
    idle(2);
    check("valid_cleared", 32'(rx_valid), 32'd0);
    drain();

    // Slow transmitter stream A..Z
    for (int c = 8'h41; c <= 8'h5A; c++) send_byte(8'(c), BIT + 1, 1'b1);
    drain();

    // Reset while receiving data bit 4 of 8'hC3
    b = 8'hC3;
    line_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) line_bit(b[i], BIT);
    line_bit(b[4], BIT / 2);
    check("mid_frame_data", 32'(dut.state == ST_DATA), 32'd1);
    rst = 1'b1;
    line_bit(b[4], BIT / 2);
    for (int i = 5; i < 8; i++) line_bit(b[i], BIT);
    line_bit(1'b1, BIT);
    rst = 1'b0;
    idle(BIT);
    check("post_reset_idle", 32'(dut.state == ST_IDLE), 32'd1);
    send_byte(8'h3C, BIT, 1'b1);
    drain();

    // Random bytes, random bit period within tolerance, random gaps
    for (int n = 0; n < 6; n++) begin
      b   = 8'($urandom);
      per = BIT + $urandom_range(1, 0);
      idle($urandom_range(40, 1));
      send_byte(b, per, 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
